// File: rtl/rx_unit.sv
// Receive half of the MiniUart: oversampled 8N1 deserializer with 3-sample
// majority vote per bit, sticky ready flag, framing and overrun flags.
module rx_unit #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       en_rx,
    input  logic       rd,
    output logic [7:0] d_out,
    output logic       rs,
    output logic       fe,
    output logic       oe
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int H  = OVERSAMPLE / 2;

    localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(H);
    localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    samp_q, samp_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    d_out_q, d_out_d;
    logic          rs_q, rs_d;
    logic          fe_q, fe_d;
    logic          oe_q, oe_d;

    logic rxs;
    logic maj;
    logic at_dec;
    logic at_wrap;

    assign rxs     = sync2_q;
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
    assign at_dec  = (cnt_q == CNT_DEC);
    assign at_wrap = (cnt_q == CNT_LAST);

    always_comb begin
        sync1_d   = rxd;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        samp_d    = samp_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        d_out_d   = d_out_q;
        rs_d      = rs_q;
        fe_d      = fe_q;
        oe_d      = oe_q;

        if (rd) begin
            rs_d = 1'b0;
            fe_d = 1'b0;
            oe_d = 1'b0;
        end

        if (en_rx) begin
            if (state_q != IDLE) begin
                cnt_d = at_wrap ? '0 : cnt_q + CW'(1);
                if (cnt_q == CNT_S0) samp_d[0] = rxs;
                if (cnt_q == CNT_S1) samp_d[1] = rxs;
            end

            case (state_q)
                // The detection tick itself is tick 0, so the count resumes at 1.
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        cnt_d   = CW'(1);
                    end
                end
                START: begin
                    if (at_dec && maj) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (at_wrap) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end
                end
                DATA: begin
                    if (at_dec) shreg_d = {maj, shreg_q[7:1]};
                    if (at_wrap) begin
                        if (bit_idx_q == 3'd7) state_d = STOP;
                        else bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                STOP: begin
                    // A read in the same cycle acknowledges the old byte, so no overrun.
                    if (at_dec) begin
                        d_out_d = shreg_q;
                        rs_d    = 1'b1;
                        fe_d    = ~maj;
                        oe_d    = rs_q & ~rd;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            samp_q    <= 2'b11;
            shreg_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            d_out_q   <= 8'h00;
            rs_q      <= 1'b0;
            fe_q      <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            samp_q    <= samp_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            d_out_q   <= d_out_d;
            rs_q      <= rs_d;
            fe_q      <= fe_d;
            oe_q      <= oe_d;
        end
    end

    assign d_out = d_out_q;
    assign rs    = rs_q;
    assign fe    = fe_q;
    assign oe    = oe_q;

endmodule

// File: tb/tb_rx_unit.sv
// Self-checking bench for rx_unit: directed scenarios plus random frames
// checked against a frame-level model of the receiver's visible registers.
module tb_rx_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       en_rx = 1'b1;
   logic       rd = 1'b0;
   logic [7:0] d_out;
   logic       rs;
   logic       fe;
   logic       oe;

   int errors = 0;
   int checks = 0;

   logic [7:0] m_dout = 8'h00;
   logic       m_rs = 1'b0;
   logic       m_fe = 1'b0;
   logic       m_oe = 1'b0;

   rx_unit #(.OVERSAMPLE(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .rxd   (rxd),
      .en_rx (en_rx),
      .rd    (rd),
      .d_out (d_out),
      .rs    (rs),
      .fe    (fe),
      .oe    (oe)
   );

   always #5 clk = ~clk;

   // Compares the visible registers against an expected value and tallies the outcome.
   task automatic checkOutput(input string name, input logic [10:0] exp);
      checks++;
      if ({d_out, rs, fe, oe} !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, {d_out, rs, fe, oe}, exp);
      end
   endtask

   // A whole received frame as the bus side sees it.
   task automatic model_complete(input logic [7:0] b, input logic stop, input logic rd_same);
      m_oe   = m_rs && !rd_same;
      m_rs   = 1'b1;
      m_fe   = !stop;
      m_dout = b;
   endtask

   task automatic model_read();
      m_rs = 1'b0;
      m_fe = 1'b0;
      m_oe = 1'b0;
   endtask

   task automatic model_reset();
      model_read();
      m_dout = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_rd();
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      model_read();
   endtask

   // Called on a negedge; drives nper bit periods of 16 clk each.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int nper);
      logic [9:0] frame;
      frame = {stop, b, 1'b0};
      for (int i = 0; i < nper; i++) begin
         rxd = frame[i];
         repeat (16) @(negedge clk);
      end
      rxd = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_values", 11'h000);
      rst = 1'b0;
      idle(4);
   endtask

   task automatic test_basic();
      int lat;
      lat = -1;
      fork
         send_frame(8'h55, 1'b1, 10);
         begin
            for (int n = 1; n <= 200; n++) begin
               @(posedge clk);
               #1;
               if (rs && lat < 0) lat = n;
            end
         end
      join
      @(negedge clk);
      model_complete(8'h55, 1'b1, 1'b0);
      checks++;
      if (lat < 153 || lat > 158) begin
         errors++;
         $display("[TB] FAIL basic_latency: got %0d expected 153..158 clk", lat);
      end
      checkOutput("basic_0x55", {m_dout, m_rs, m_fe, m_oe});
   endtask

   task automatic test_glitch();
      pulse_rd();
      idle(4);
      rxd = 1'b0;
      idle(4);
      rxd = 1'b1;
      idle(40);
      checkOutput("glitch", {m_dout, m_rs, m_fe, m_oe});
      send_frame(8'hC6, 1'b1, 10);
      model_complete(8'hC6, 1'b1, 1'b0);
      checkOutput("after_glitch", {m_dout, m_rs, m_fe, m_oe});
      pulse_rd();
   endtask

   task automatic test_framing();
      idle(8);
      send_frame(8'hA3, 1'b0, 10);
      idle(24);
      model_complete(8'hA3, 1'b0, 1'b0);
      checkOutput("framing", {m_dout, m_rs, m_fe, m_oe});
      pulse_rd();
      idle(1);
      checkOutput("framing_rd", {m_dout, m_rs, m_fe, m_oe});
   endtask

   task automatic test_back_to_back();
      idle(8);
      send_frame(8'h12, 1'b1, 10);
      model_complete(8'h12, 1'b1, 1'b0);
      send_frame(8'h34, 1'b1, 10);
      model_complete(8'h34, 1'b1, 1'b0);
      checkOutput("overrun", {m_dout, m_rs, m_fe, m_oe});
      pulse_rd();
      idle(1);
      checkOutput("overrun_rd", {m_dout, m_rs, m_fe, m_oe});
   endtask

   // Completion lands on the 156th rising edge after the start bit is driven.
   task automatic test_rd_collision();
      idle(8);
      send_frame(8'h5A, 1'b1, 10);
      model_complete(8'h5A, 1'b1, 1'b0);
      idle(8);
      fork
         send_frame(8'h7E, 1'b1, 10);
         begin
            repeat (155) @(posedge clk);
            @(negedge clk);
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
         end
      join
      model_complete(8'h7E, 1'b1, 1'b1);
      checkOutput("rd_collision", {m_dout, m_rs, m_fe, m_oe});
   endtask

   task automatic test_reset_midframe();
      idle(8);
      send_frame(8'hFF, 1'b1, 5);
      idle(8);
      #2 rst = 1'b1;
      #1;
      model_reset();
      checkOutput("midframe_reset", {m_dout, m_rs, m_fe, m_oe});
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(20);
      send_frame(8'h0F, 1'b1, 10);
      model_complete(8'h0F, 1'b1, 1'b0);
      checkOutput("after_reset_0x0F", {m_dout, m_rs, m_fe, m_oe});
      pulse_rd();
   endtask

   task automatic test_loopback();
      logic [7:0] b;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       b = 8'h00;
            1:       b = 8'hFF;
            default: b = 8'h80;
         endcase
         idle(4);
         send_frame(b, 1'b1, 10);
         model_complete(b, 1'b1, 1'b0);
         checkOutput($sformatf("loopback_%0d", i), {m_dout, m_rs, m_fe, m_oe});
         pulse_rd();
      end
   endtask

   // A low stop bit is followed by a long idle so it is not taken as the next start.
   task automatic test_random();
      logic [7:0] b;
      logic       stop;
      for (int i = 0; i < 12; i++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         send_frame(b, stop, 10);
         model_complete(b, stop, 1'b0);
         if (!stop) idle(24);
         else idle($urandom_range(0, 6));
         checkOutput($sformatf("random_%0d", i), {m_dout, m_rs, m_fe, m_oe});
         if ($urandom_range(0, 1) == 1) pulse_rd();
      end
   endtask

   // Runs every scenario in order and reports the tally of failed checks.
   initial begin
      $display("[TB] rx_unit bench start");
      test_reset();
      test_basic();
      test_glitch();
      test_framing();
      test_back_to_back();
      test_rd_collision();
      test_reset_midframe();
      test_loopback();
      test_random();
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Stops a hung simulation.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
